// File: rtl/lap_timer_if.sv
// lap_timer_if: mode inputs, lap controls and stopwatch/lap outputs of the
// lap timer. The sat signal exists only when LAP_TIMER_SAT_EN is defined.
interface lap_timer_if #(
  parameter int LAP_DEPTH = 4
);
  localparam int CW = $clog2(LAP_DEPTH + 1);

  logic [1:0]    mode1;
  logic [1:0]    mode2;
  logic          lap_pulse;
  logic          lap_rd;
  logic [5:0]    min_sw;
  logic [5:0]    sec_sw;
  logic [5:0]    secc_sw;
  logic          lap_valid;
  logic [5:0]    lap_min;
  logic [5:0]    lap_sec;
  logic [5:0]    lap_secc;
  logic [CW-1:0] lap_count;
  logic          lap_full;
  logic          lap_ovf;
`ifdef LAP_TIMER_SAT_EN
  logic          sat;

  modport master (
    output mode1, mode2, lap_pulse, lap_rd,
    input  min_sw, sec_sw, secc_sw, lap_valid, lap_min, lap_sec, lap_secc,
    input  lap_count, lap_full, lap_ovf, sat
  );

  modport slave (
    input  mode1, mode2, lap_pulse, lap_rd,
    output min_sw, sec_sw, secc_sw, lap_valid, lap_min, lap_sec, lap_secc,
    output lap_count, lap_full, lap_ovf, sat
  );
`else
  modport master (
    output mode1, mode2, lap_pulse, lap_rd,
    input  min_sw, sec_sw, secc_sw, lap_valid, lap_min, lap_sec, lap_secc,
    input  lap_count, lap_full, lap_ovf
  );

  modport slave (
    input  mode1, mode2, lap_pulse, lap_rd,
    output min_sw, sec_sw, secc_sw, lap_valid, lap_min, lap_sec, lap_secc,
    output lap_count, lap_full, lap_ovf
  );
`endif
endinterface

// File: rtl/lap_timer.sv
// lap_timer: stopwatch (minutes / seconds / tenths) with pause/resume and a
// first-word fall-through lap capture FIFO with sticky overflow flag.
// Optional macro LAP_TIMER_SAT_EN: saturate at MAX_MIN:59.9 and drive sat.
module lap_timer #(
  parameter int         CLOCKS4TICK    = 10,
  parameter int         LAP_DEPTH      = 4,
  parameter int         MAX_MIN        = 59,
  parameter logic [1:0] M1_TIMER       = 2'd2,
  parameter logic [1:0] M2_TIMER_G     = 2'd0,
  parameter logic [1:0] M2_TIMER_START = 2'd1,
  parameter logic [1:0] M2_TIMER_STOP  = 2'd2
) (
  input logic        clk,
  input logic        reset_n,
  lap_timer_if.slave bus
);

  localparam int PW   = (CLOCKS4TICK > 1) ? $clog2(CLOCKS4TICK) : 1;
  localparam int CW   = $clog2(LAP_DEPTH + 1);
  localparam int PTRW = $clog2(LAP_DEPTH);
  localparam logic [PW-1:0]   PRESC_MAX = PW'(CLOCKS4TICK - 1);
  localparam logic [PTRW-1:0] PTR_LAST  = PTRW'(LAP_DEPTH - 1);
  localparam logic [CW-1:0]   CNT_FULL  = CW'(LAP_DEPTH);
  localparam logic [5:0]      MAX_MIN6  = 6'(MAX_MIN);

  typedef enum logic [1:0] {
    ST_CLEARED = 2'b00,
    ST_RUN     = 2'b01,
    ST_PAUSED  = 2'b10
  } state_t;

  state_t          state_q, state_d;
  logic            clear_s, run_s, hold_s, advance_s, tick_s;
  logic [PW-1:0]   presc_q;
  logic [5:0]      min_q, sec_q, secc_q;
  logic [5:0]      min_inc_s, sec_inc_s, secc_inc_s;
  logic [17:0]     mem_q [LAP_DEPTH];
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            push_req_s, push_ok_s, pop_ok_s;
  logic [17:0]     push_data_s, head_q, head_d;
  logic            valid_q, full_q;

  // Circular pointer advance that works for non power-of-two depths.
  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    if (p == PTR_LAST) begin
      return {PTRW{1'b0}};
    end else begin
      return p + PTRW'(1);
    end
  endfunction

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_CLEARED;
    end else begin
      state_q <= state_d;
    end
  end

  // Mode decode: clear conditions take priority, STOP only pauses a running timer.
  always_comb begin
    state_d = state_q;
    clear_s = 1'b0;
    if (bus.mode1 != M1_TIMER) begin
      state_d = ST_CLEARED;
      clear_s = 1'b1;
    end else begin
      case (bus.mode2)
        M2_TIMER_G: begin
          state_d = ST_CLEARED;
          clear_s = 1'b1;
        end
        M2_TIMER_START: state_d = ST_RUN;
        M2_TIMER_STOP: begin
          if (state_q == ST_CLEARED) begin
            state_d = ST_CLEARED;
          end else begin
            state_d = ST_PAUSED;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Counting and lap capture act in the cycle whose decoded state is RUN.
  assign run_s = (state_d == ST_RUN);

`ifdef LAP_TIMER_SAT_EN
  logic at_max_s, inc_at_max_s, sat_q;
  assign at_max_s     = (min_q == MAX_MIN6) && (sec_q == 6'd59) && (secc_q == 6'd9);
  assign inc_at_max_s = (min_inc_s == MAX_MIN6) && (sec_inc_s == 6'd59) && (secc_inc_s == 6'd9);
  assign hold_s       = at_max_s;
`else
  assign hold_s = 1'b0;
`endif

  assign advance_s = run_s && !hold_s;
  assign tick_s    = advance_s && (presc_q == PRESC_MAX);

  // Single-cycle sum-and-carry of the time by one tenth.
  always_comb begin
    secc_inc_s = secc_q;
    sec_inc_s  = sec_q;
    min_inc_s  = min_q;
    if (secc_q == 6'd9) begin
      secc_inc_s = 6'd0;
      if (sec_q == 6'd59) begin
        sec_inc_s = 6'd0;
        if (min_q == MAX_MIN6) begin
          min_inc_s = 6'd0;
        end else begin
          min_inc_s = min_q + 6'd1;
        end
      end else begin
        sec_inc_s = sec_q + 6'd1;
      end
    end else begin
      secc_inc_s = secc_q + 6'd1;
    end
  end

  // Prescaler and time registers; paused/held states keep prescaler phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= {PW{1'b0}};
      min_q   <= 6'd0;
      sec_q   <= 6'd0;
      secc_q  <= 6'd0;
    end else if (clear_s) begin
      presc_q <= {PW{1'b0}};
      min_q   <= 6'd0;
      sec_q   <= 6'd0;
      secc_q  <= 6'd0;
    end else if (tick_s) begin
      presc_q <= {PW{1'b0}};
      min_q   <= min_inc_s;
      sec_q   <= sec_inc_s;
      secc_q  <= secc_inc_s;
    end else if (advance_s) begin
      presc_q <= presc_q + PW'(1);
    end
  end

`ifdef LAP_TIMER_SAT_EN
  // Saturation flag follows the time into and out of MAX_MIN:59.9.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sat_q <= 1'b0;
    end else if (clear_s) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= tick_s ? inc_at_max_s : at_max_s;
    end
  end
`endif

  // A push may use the slot freed by a simultaneous pop; pops need data.
  assign push_data_s = {min_q, sec_q, secc_q};
  assign push_req_s  = run_s && bus.lap_pulse;
  assign pop_ok_s    = !clear_s && bus.lap_rd && (count_q != {CW{1'b0}});
  assign push_ok_s   = push_req_s && ((count_q != CNT_FULL) || pop_ok_s);

  // FIFO pointer, occupancy and overflow next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (clear_s) begin
      wr_ptr_d = {PTRW{1'b0}};
      rd_ptr_d = {PTRW{1'b0}};
      count_d  = {CW{1'b0}};
      ovf_d    = 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (push_ok_s && !pop_ok_s) begin
        count_d = count_q + CW'(1);
      end else if (pop_ok_s && !push_ok_s) begin
        count_d = count_q - CW'(1);
      end else begin
        count_d = count_q;
      end
      if (push_req_s && !push_ok_s) begin
        ovf_d = 1'b1;
      end else begin
        ovf_d = ovf_q;
      end
    end
  end

  // Next head value, bypassing the write when the new entry becomes the head.
  always_comb begin
    head_d = 18'd0;
    if (count_d == {CW{1'b0}}) begin
      head_d = 18'd0;
    end else if (push_ok_s && (wr_ptr_q == rd_ptr_d)) begin
      head_d = push_data_s;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  // Lap storage; contents are only observed through the registered head.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= push_data_s;
    end
  end

  // FIFO control state and registered lap outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= {PTRW{1'b0}};
      rd_ptr_q <= {PTRW{1'b0}};
      count_q  <= {CW{1'b0}};
      ovf_q    <= 1'b0;
      head_q   <= 18'd0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      head_q   <= head_d;
      valid_q  <= (count_d != {CW{1'b0}});
      full_q   <= (count_d == CNT_FULL);
    end
  end

  assign bus.min_sw    = min_q;
  assign bus.sec_sw    = sec_q;
  assign bus.secc_sw   = secc_q;
  assign bus.lap_valid = valid_q;
  assign bus.lap_min   = head_q[17:12];
  assign bus.lap_sec   = head_q[11:6];
  assign bus.lap_secc  = head_q[5:0];
  assign bus.lap_count = count_q;
  assign bus.lap_full  = full_q;
  assign bus.lap_ovf   = ovf_q;
`ifdef LAP_TIMER_SAT_EN
  assign bus.sat       = sat_q;
`endif

endmodule

// File: tb/tb_lap_timer.sv
// tb_lap_timer: directed self-checking bench for lap_timer with
// CLOCKS4TICK=2, LAP_DEPTH=4, MAX_MIN=1.
module tb_lap_timer;
  localparam logic [1:0] M1_CLOCK = 2'd0;
  localparam logic [1:0] M1_TIMER = 2'd2;
  localparam logic [1:0] M2_G     = 2'd0;
  localparam logic [1:0] M2_START = 2'd1;
  localparam logic [1:0] M2_STOP  = 2'd2;
  localparam logic [1:0] M2_HOLD  = 2'd3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   exp_t4 [5] = '{3, 6, 10, 13, 17};

  lap_timer_if #(.LAP_DEPTH(4)) tif();

  lap_timer #(
    .CLOCKS4TICK(2), .LAP_DEPTH(4), .MAX_MIN(1),
    .M1_TIMER(M1_TIMER), .M2_TIMER_G(M2_G),
    .M2_TIMER_START(M2_START), .M2_TIMER_STOP(M2_STOP)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(tif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_time(input string tag, input int m, input int s, input int c);
    chk({tag, "_min"}, 32'(tif.min_sw), m);
    chk({tag, "_sec"}, 32'(tif.sec_sw), s);
    chk({tag, "_secc"}, 32'(tif.secc_sw), c);
  endtask

  task automatic chk_head(input string tag, input int tenths);
    chk({tag, "_valid"}, 32'(tif.lap_valid), 1);
    chk({tag, "_min"}, 32'(tif.lap_min), 0);
    chk({tag, "_sec"}, 32'(tif.lap_sec), tenths / 10);
    chk({tag, "_secc"}, 32'(tif.lap_secc), tenths % 10);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    tif.mode1 = M1_CLOCK;
    tif.mode2 = M2_G;
    tif.lap_pulse = 1'b0;
    tif.lap_rd = 1'b0;
    cyc(2);
    chk_time("reset", 0, 0, 0);
    chk("reset_valid", 32'(tif.lap_valid), 0);
    chk("reset_count", 32'(tif.lap_count), 0);
    chk("reset_full", 32'(tif.lap_full), 0);
    chk("reset_ovf", 32'(tif.lap_ovf), 0);
    reset_n = 1'b1;
    cyc(1);

    // 20 cycles of START at two cycles per tick gives one second
    tif.mode1 = M1_TIMER;
    tif.mode2 = M2_START;
    cyc(20);
    chk_time("run20", 0, 1, 0);
    tif.mode2 = M2_G;
    cyc(1);
    chk_time("g_clear", 0, 0, 0);

    // pause/resume keeps the prescaler phase
    tif.mode2 = M2_START;
    cyc(7);
    chk_time("run7", 0, 0, 3);
    tif.mode2 = M2_STOP;
    cyc(1);
    chk_time("stop1", 0, 0, 3);
    cyc(9);
    chk_time("stop10", 0, 0, 3);
    tif.mode2 = M2_START;
    cyc(1);
    chk_time("resume", 0, 0, 4);
    tif.mode2 = M2_HOLD;
    cyc(2);
    chk_time("hold_run", 0, 0, 5);
    tif.mode2 = M2_G;
    cyc(1);

    // carry into minutes and wrap / saturate at MAX_MIN:59.9
    tif.mode2 = M2_START;
    cyc(1198);
    chk_time("t0059", 0, 59, 9);
    cyc(2);
    chk_time("t0100", 1, 0, 0);
    cyc(1198);
    chk_time("t0159", 1, 59, 9);
    cyc(2);
`ifdef LAP_TIMER_SAT_EN
    chk_time("sat", 1, 59, 9);
    chk("sat_flag", 32'(tif.sat), 1);
    cyc(6);
    chk_time("sat_hold", 1, 59, 9);
`else
    chk_time("wrap", 0, 0, 0);
`endif
    tif.mode1 = M1_CLOCK;
    cyc(1);
    chk_time("m1_clear", 0, 0, 0);
`ifdef LAP_TIMER_SAT_EN
    chk("sat_clear", 32'(tif.sat), 0);
`endif
    tif.mode1 = M1_TIMER;
    tif.mode2 = M2_G;
    cyc(1);

    // five captures into a four-deep FIFO
    tif.mode2 = M2_START;
    for (int i = 0; i < 5; i++) begin
      cyc(6);
      tif.lap_pulse = 1'b1;
      cyc(1);
      tif.lap_pulse = 1'b0;
      if (i == 0) begin
        chk_head("first_lap", 3);
        chk("first_count", 32'(tif.lap_count), 1);
      end
    end
    chk("ovf_full", 32'(tif.lap_full), 1);
    chk("ovf_flag", 32'(tif.lap_ovf), 1);
    chk("ovf_count", 32'(tif.lap_count), 4);
    chk_time("t4_time", 0, 1, 7);
    tif.mode2 = M2_STOP;
    cyc(1);
    for (int i = 0; i < 4; i++) begin
      chk_head("pop_head", exp_t4[i]);
      tif.lap_rd = 1'b1;
      cyc(1);
      tif.lap_rd = 1'b0;
    end
    chk("empty_valid", 32'(tif.lap_valid), 0);
    chk("empty_min", 32'(tif.lap_min), 0);
    chk("empty_sec", 32'(tif.lap_sec), 0);
    chk("empty_secc", 32'(tif.lap_secc), 0);
    chk("empty_count", 32'(tif.lap_count), 0);
    chk("empty_full", 32'(tif.lap_full), 0);
    chk("ovf_sticky", 32'(tif.lap_ovf), 1);
    tif.lap_pulse = 1'b1;
    cyc(1);
    tif.lap_pulse = 1'b0;
    chk("paused_pulse", 32'(tif.lap_count), 0);
    tif.lap_rd = 1'b1;
    cyc(1);
    tif.lap_rd = 1'b0;
    chk("empty_rd_count", 32'(tif.lap_count), 0);
    chk("empty_rd_valid", 32'(tif.lap_valid), 0);
    chk_time("paused_time", 0, 1, 7);

    // simultaneous push and pop, full then empty
    tif.mode2 = M2_G;
    cyc(1);
    chk("g_ovf_clear", 32'(tif.lap_ovf), 0);
    tif.mode2 = M2_START;
    for (int i = 0; i < 4; i++) begin
      tif.lap_pulse = 1'b1;
      cyc(1);
      tif.lap_pulse = 1'b0;
      cyc(1);
    end
    chk("fill_count", 32'(tif.lap_count), 4);
    chk_head("fill_head", 0);
    tif.lap_pulse = 1'b1;
    tif.lap_rd = 1'b1;
    cyc(1);
    tif.lap_pulse = 1'b0;
    tif.lap_rd = 1'b0;
    chk("pp_full_count", 32'(tif.lap_count), 4);
    chk("pp_full_full", 32'(tif.lap_full), 1);
    chk("pp_full_ovf", 32'(tif.lap_ovf), 0);
    tif.mode2 = M2_STOP;
    for (int i = 1; i <= 4; i++) begin
      chk_head("pp_pop", i);
      tif.lap_rd = 1'b1;
      cyc(1);
      tif.lap_rd = 1'b0;
    end
    chk("pp_drained", 32'(tif.lap_count), 0);
    tif.mode2 = M2_START;
    tif.lap_pulse = 1'b1;
    tif.lap_rd = 1'b1;
    cyc(1);
    tif.lap_pulse = 1'b0;
    tif.lap_rd = 1'b0;
    chk("pp_empty_count", 32'(tif.lap_count), 1);
    chk_head("pp_empty_head", 4);

    // clear with three entries and overflow set
    tif.lap_pulse = 1'b1;
    cyc(4);
    tif.lap_pulse = 1'b0;
    chk("t6_count4", 32'(tif.lap_count), 4);
    chk("t6_ovf", 32'(tif.lap_ovf), 1);
    tif.lap_rd = 1'b1;
    cyc(1);
    tif.lap_rd = 1'b0;
    chk("t6_count3", 32'(tif.lap_count), 3);
    tif.mode2 = M2_G;
    cyc(1);
    chk_time("t6_clear", 0, 0, 0);
    chk("t6_clr_count", 32'(tif.lap_count), 0);
    chk("t6_clr_ovf", 32'(tif.lap_ovf), 0);
    chk("t6_clr_valid", 32'(tif.lap_valid), 0);

    // asynchronous reset in the middle of a tick
    tif.mode2 = M2_START;
    cyc(3);
    tif.lap_pulse = 1'b1;
    cyc(1);
    tif.lap_pulse = 1'b0;
    chk_time("pre_reset", 0, 0, 2);
    chk("pre_reset_count", 32'(tif.lap_count), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_time("async_reset", 0, 0, 0);
    chk("async_valid", 32'(tif.lap_valid), 0);
    chk("async_count", 32'(tif.lap_count), 0);
    chk("async_secc_head", 32'(tif.lap_secc), 0);
    @(negedge clk);
    reset_n = 1'b1;
    cyc(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/lap_timer.md
Name: lap_timer

Overview:
Stopwatch for the digital clock, parametrised successor of the TIMER block. Counts minutes, seconds and tenths of a second while mode1/mode2 from MODE_GEN select the TIMER start mode. Adds a pause/resume state, a lap (split) capture FIFO of configurable depth with overflow flagging, and configurable prescaler and minute range. Sits beside the clock and alarm blocks; its outputs feed the display mux.

Parameters:
CLOCKS4TICK, 10, clk rising edges per 0.1 s tick; must be ≥1, and 1 means a tick every cycle.
LAP_DEPTH, 4, number of lap FIFO entries; must be ≥2, need not be a power of 2.
MAX_MIN, 59, largest minute value before wrap; must be ≤63.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous reset, active low
mode1  in  2  major mode from MODE_GEN (shared M1_* encodings)
mode2  in  2  minor mode from MODE_GEN (shared M2_TIMER_G / M2_TIMER_START / M2_TIMER_STOP)
lap_pulse  in  1  one-cycle lap capture request
lap_rd  in  1  one-cycle pop of FIFO head
min_sw  out  6  running minutes
sec_sw  out  6  running seconds, 0..59
secc_sw  out  6  running tenths, 0..9
lap_valid  out  1  FIFO not empty
lap_min / lap_sec / lap_secc  out  6 each  FIFO head value (first-word fall-through); 0 when empty
lap_count  out  clog2(LAP_DEPTH+1)  entries held
lap_full  out  1  lap_count == LAP_DEPTH
lap_ovf  out  1  sticky: a capture was dropped

Behaviour:
- Reset: every output is 0. Prescaler is 0, FIFO is empty, FSM is in CLEARED.
- All state is updated on the rising edge of clk. All outputs are registered.
- FSM states are CLEARED, RUN and PAUSED, evaluated each cycle in priority order:
  - mode1 != M1_TIMER → CLEARED. Time, prescaler and FIFO are cleared and lap_ovf is cleared.
  - mode2 == M2_TIMER_G → CLEARED, with the same clears.
  - mode2 == M2_TIMER_START → RUN.
  - mode2 == M2_TIMER_STOP → PAUSED if currently RUN, otherwise stay in CLEARED.
  - Any other mode2 value holds the current state.
- RUN:
  - Prescaler counts 0..CLOCKS4TICK-1. When it is at CLOCKS4TICK-1 it returns to 0 and a tick is issued.
  - On a tick, secc_sw increments. At 9 it rolls to 0 and carries into sec_sw. sec_sw at 59 rolls to 0 and carries into min_sw. min_sw at MAX_MIN wraps to 0.
  - Sum-and-carry happens in a single cycle; there is no multi-cycle ripple.
- PAUSED: time and prescaler hold, and resuming continues mid-tick with no prescaler reset. STOP→START→STOP sequences accumulate time correctly.
- Lap capture is honoured only in RUN; lap_pulse in PAUSED or CLEARED is ignored.
  - The pushed value is {min_sw, sec_sw, secc_sw} as registered before that edge's increment.
  - It is visible on lap_* one cycle later if the FIFO was empty.
- Pop: lap_rd with lap_valid removes the head. lap_rd while empty is ignored and leaves no state change.
- Simultaneous push and pop:
  - When full, both succeed and the count is unchanged.
  - When empty, the push succeeds, the pop is ignored and count becomes 1.
- Push when full without a pop: the entry is dropped, lap_ovf is set to 1 and held until the next clear, and FIFO contents are unchanged.
- lap_rd is honoured in every state except on a clear cycle, where the clear wins.
- Reset asserted mid-operation: immediate return to the reset values regardless of clk.

Optional Feature:
LAP_TIMER_SAT_EN.
- Defined: at MAX_MIN:59.9 the counter saturates instead of wrapping. It stays in RUN but time and prescaler hold, and lap captures still push the saturated value. An extra output port, sat, is 1 while saturated and cleared together with the time.
- Undefined: wrap to 00:00.0 as above, and there is no sat port.

Test Plan:
1. Use CLOCKS4TICK=2 with START held for 20 cycles → secc_sw=0, sec_sw=1, min_sw=0.
2. START for 7 cycles, then STOP for 10, then START for 1 → secc_sw=4. During STOP no output changes; prescaler resumes, giving a tick on the 8th RUN cycle.
3. With the time preloaded by running to 00:59.9, apply 2 more cycles → 01:00.0. With MAX_MIN=1, at 01:59.9 the next tick wraps to 00:00.0; with LAP_TIMER_SAT_EN the time stays at 01:59.9 and sat=1.
4. Send 5 lap_pulses in RUN at times t1..t5 with LAP_DEPTH=4 → lap_full=1 and lap_ovf=1. Popping 4 returns t1..t4 in order, then lap_valid=0 and lap_* =0.
5. lap_pulse and lap_rd in the same cycle, with the FIFO full, then with it empty → count stays 4 with the head advanced; count becomes 1 with the new entry at the head.
6. mode2=M2_TIMER_G with the FIFO holding 3 entries and lap_ovf=1 → next cycle the time is 0, lap_count=0 and lap_ovf=0. reset_n low mid-tick → all outputs 0 asynchronously.
